// File: rtl/demux16b4_buf.sv
// demux16b4_buf: buffered 1-to-4 demultiplexer, one producer stream steered into four per-channel FIFOs
// Ports: clk/rst (sync active-high reset); in_valid/in_ready/in_data/in_sel producer handshake;
//        out_valid[i]/out_ready[i]/out_data0..3 per-channel consumer handshakes; occ packed occupancy counts.
// Optional: define DEMUX16B4_BCAST_EN to add in_bcast, which pushes one word into all four FIFOs atomically.
module demux16b4_buf #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_sel,
`ifdef DEMUX16B4_BCAST_EN
    input  logic             in_bcast,
`endif
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic [WIDTH-1:0] out_data0,
    output logic [WIDTH-1:0] out_data1,
    output logic [WIDTH-1:0] out_data2,
    output logic [WIDTH-1:0] out_data3,
    output logic [4*CW-1:0]  occ
);
    localparam int PW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [4][DEPTH];
    logic [CW-1:0]    cnt [4];
    logic [PW-1:0]    hd [4];
    logic [PW-1:0]    tl [4];
    logic [3:0]       full;
    logic [3:0]       push;
    logic [3:0]       pop;
    for (genvar i = 0; i < 4; i++) begin : g_ch
        assign full[i]           = cnt[i] == CW'(DEPTH);
        assign out_valid[i]      = cnt[i] != '0;
        assign occ[i*CW +: CW]   = cnt[i];
    end
    // Readiness uses the registered counts only, so a full channel refuses a push even when it pops this cycle.
`ifdef DEMUX16B4_BCAST_EN
    assign in_ready = in_bcast ? ~|full : ~full[in_sel];
    assign push     = {4{in_valid && in_ready}} & (in_bcast ? 4'hf : 4'b0001 << in_sel);
`else
    assign in_ready = ~full[in_sel];
    assign push     = {4{in_valid && in_ready}} & (4'b0001 << in_sel);
`endif
    assign pop       = out_valid & out_ready;
    assign out_data0 = mem[0][hd[0]];
    assign out_data1 = mem[1][hd[1]];
    assign out_data2 = mem[2][hd[2]];
    assign out_data3 = mem[3][hd[3]];
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < 4; c++) begin
                cnt[c] <= '0;
                hd[c]  <= '0;
                tl[c]  <= '0;
                for (int d = 0; d < DEPTH; d++) mem[c][d] <= '0;
            end
        end else begin
            for (int c = 0; c < 4; c++) begin
                if (push[c]) begin
                    mem[c][tl[c]] <= in_data;
                    tl[c]         <= tl[c] + PW'(1);
                end
                if (pop[c]) hd[c] <= hd[c] + PW'(1);
                cnt[c] <= cnt[c] + CW'(push[c]) - CW'(pop[c]);
            end
        end
    end
endmodule
